// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: merges several masters onto one slave port,
// tracks outstanding requests in an ID FIFO and routes responses in order.
module sram_like_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4,
  parameter int RR_MODE   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            m_req,
  input  logic [NUM_CH-1:0]            m_wr,
  input  logic [2*NUM_CH-1:0]          m_size,
  input  logic [NUM_CH*DATA_W/8-1:0]   m_wstrb,
  input  logic [NUM_CH*ADDR_W-1:0]     m_addr,
  input  logic [NUM_CH*DATA_W-1:0]     m_wdata,
  output logic [NUM_CH-1:0]            m_addr_ok,
  output logic [NUM_CH-1:0]            m_data_ok,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         s_req,
  output logic                         s_wr,
  output logic [1:0]                   s_size,
  output logic [DATA_W/8-1:0]          s_wstrb,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  input  logic                         s_addr_ok,
  input  logic                         s_data_ok,
  input  logic [DATA_W-1:0]            s_rdata,
  output logic [$clog2(MAX_OUTST):0]   outst_cnt,
  output logic                         err_unexp
);
  localparam int SW   = DATA_W / 8;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW   = $clog2(MAX_OUTST);
  localparam int CNTW = PW + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   lock_ch_q, lock_ch_d;
  logic [CW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]   gnt;
  logic            gnt_vld;
  logic [CW-1:0]   fifo_q [MAX_OUTST];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q;
  logic            full, empty, push, pop;

  // Grant select; descending loops let the lowest search offset win.
  always_comb begin : grant_sel
    logic [CW:0] idx;
    gnt     = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    if (state_q == LOCK) begin
      gnt     = lock_ch_q;
      gnt_vld = m_req[lock_ch_q];
    end else if (RR_MODE == 0) begin
      for (int i = NUM_CH-1; i >= 0; i--) begin
        if (m_req[i]) begin
          gnt     = CW'(i);
          gnt_vld = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_CH-1; i >= 0; i--) begin
        idx = {1'b0, rr_ptr_q} + (CW+1)'(i);
        if (idx >= (CW+1)'(NUM_CH)) idx = idx - (CW+1)'(NUM_CH);
        if (m_req[idx]) begin
          gnt     = idx[CW-1:0];
          gnt_vld = 1'b1;
        end
      end
    end
  end

  assign full  = (cnt_q == CNTW'(MAX_OUTST));
  assign empty = (cnt_q == '0);
  assign s_req = gnt_vld & ~full & ~reset;
  assign push  = s_req & s_addr_ok;
  assign pop   = s_data_ok & ~empty & ~reset;

  assign s_wr    = m_wr[gnt];
  assign s_size  = m_size[gnt*2 +: 2];
  assign s_wstrb = m_wstrb[gnt*SW +: SW];
  assign s_addr  = m_addr[gnt*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[gnt*DATA_W +: DATA_W];
  assign m_rdata = s_rdata;

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int g = 0; g < NUM_CH; g++)
      m_addr_ok[g] = push & (gnt == CW'(g));
    if (pop) m_data_ok[fifo_q[rptr_q]] = 1'b1;
  end

  // A stalled grant is frozen so the slave sees stable fields until accept.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q + CNTW'(push) - CNTW'(pop);
    case (state_q)
      IDLE: if (s_req && !s_addr_ok) begin
        state_d   = LOCK;
        lock_ch_d = gnt;
      end
      LOCK: if (push) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push) rr_ptr_d = (gnt == CW'(NUM_CH-1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (s_data_ok && empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= gnt;
  end

  assign outst_cnt = cnt_q;
  assign err_unexp = err_q;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: instance A is 2-channel fixed priority, instance B is
// 3-channel round-robin; both share clock and reset.
module tb_sram_like_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0]  a_req, a_wr, a_aok, a_dok;
  logic [3:0]  a_size;
  logic [7:0]  a_wstrb;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_saddr, a_swdata, a_srdata;
  logic        a_sreq, a_swr, a_saok, a_sdok, a_err;
  logic [1:0]  a_ssize;
  logic [3:0]  a_swstrb;
  logic [2:0]  a_cnt;

  logic [2:0]  b_req, b_wr, b_aok, b_dok;
  logic [5:0]  b_size;
  logic [11:0] b_wstrb;
  logic [95:0] b_addr, b_wdata;
  logic [31:0] b_rdata, b_saddr, b_swdata, b_srdata;
  logic        b_sreq, b_swr, b_saok, b_sdok, b_err;
  logic [1:0]  b_ssize;
  logic [3:0]  b_swstrb;
  logic [2:0]  b_cnt;

  int n_asrt = 0;
  int n_fail = 0;

  sram_like_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .m_req(a_req), .m_wr(a_wr), .m_size(a_size),
    .m_wstrb(a_wstrb), .m_addr(a_addr), .m_wdata(a_wdata), .m_addr_ok(a_aok),
    .m_data_ok(a_dok), .m_rdata(a_rdata), .s_req(a_sreq), .s_wr(a_swr),
    .s_size(a_ssize), .s_wstrb(a_swstrb), .s_addr(a_saddr), .s_wdata(a_swdata),
    .s_addr_ok(a_saok), .s_data_ok(a_sdok), .s_rdata(a_srdata),
    .outst_cnt(a_cnt), .err_unexp(a_err));

  sram_like_arbiter #(.NUM_CH(3), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4), .RR_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .m_req(b_req), .m_wr(b_wr), .m_size(b_size),
    .m_wstrb(b_wstrb), .m_addr(b_addr), .m_wdata(b_wdata), .m_addr_ok(b_aok),
    .m_data_ok(b_dok), .m_rdata(b_rdata), .s_req(b_sreq), .s_wr(b_swr),
    .s_size(b_ssize), .s_wstrb(b_swstrb), .s_addr(b_saddr), .s_wdata(b_swdata),
    .s_addr_ok(b_saok), .s_data_ok(b_sdok), .s_rdata(b_srdata),
    .outst_cnt(b_cnt), .err_unexp(b_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_req = '0; a_wr = 2'b10; a_size = {2'd2, 2'd0}; a_wstrb = {4'hF, 4'h1};
    a_addr = {32'h20, 32'h10}; a_wdata = {32'hD1, 32'hD0};
    a_saok = 1'b0; a_sdok = 1'b0; a_srdata = '0;
    b_req = '0; b_wr = '0; b_size = '0; b_wstrb = '0; b_wdata = '0;
    b_addr = {32'h1002, 32'h1001, 32'h1000};
    b_saok = 1'b0; b_sdok = 1'b0; b_srdata = '0;
    step(); step();

    // reset state and gating while reset is high
    a_req = 2'b11; a_saok = 1'b1; a_sdok = 1'b1; #1;
    chk("rst_sreq", a_sreq, 0);
    chk("rst_aok", a_aok, 0);
    chk("rst_dok", a_dok, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_err", a_err, 0);
    step();
    reset = 1'b0; a_sdok = 1'b0;

    // fixed priority: ch0 wins every cycle, responses 2 cycles later
    #1;
    chk("fp_aok0", a_aok, 2'b01);
    chk("fp_saddr0", a_saddr, 32'h10);
    step(); #1;
    chk("fp_cnt1", a_cnt, 1);
    chk("fp_aok1", a_aok, 2'b01);
    step();
    a_sdok = 1'b1; #1;
    chk("fp_dok2", a_dok, 2'b01);
    chk("fp_aok2", a_aok, 2'b01);
    chk("fp_cnt2", a_cnt, 2);
    step(); #1;
    chk("fp_cnt3", a_cnt, 2);
    chk("fp_aok3", a_aok, 2'b01);
    step();
    a_req = 2'b00; #1;
    chk("fp_drain_cnt", a_cnt, 2);
    step(); step();
    a_sdok = 1'b0; #1;
    chk("fp_empty", a_cnt, 0);
    step();

    // round robin on 3 channels
    b_req = 3'b111; b_saok = 1'b1; #1;
    chk("rr_aok0", b_aok, 3'b001);
    chk("rr_saddr0", b_saddr, 32'h1000);
    step(); #1;
    chk("rr_aok1", b_aok, 3'b010);
    chk("rr_saddr1", b_saddr, 32'h1001);
    step();
    b_sdok = 1'b1; #1;
    chk("rr_aok2", b_aok, 3'b100);
    chk("rr_dok2", b_dok, 3'b001);
    step(); #1;
    chk("rr_aok3", b_aok, 3'b001);
    chk("rr_dok3", b_dok, 3'b010);
    step(); #1;
    chk("rr_aok4", b_aok, 3'b010);
    chk("rr_dok4", b_dok, 3'b100);
    step();
    b_req = 3'b000; #1;
    chk("rr_dok5", b_dok, 3'b001);
    step(); #1;
    chk("rr_dok6", b_dok, 3'b010);
    step();
    b_sdok = 1'b0; b_saok = 1'b0; #1;
    chk("rr_cnt_end", b_cnt, 0);
    chk("rr_err", b_err, 0);

    // lock: ch1 stalled, ch0 arrives later but must wait
    a_req = 2'b10; a_saok = 1'b0; #1;
    chk("lk_sreq", a_sreq, 1);
    chk("lk_saddr0", a_saddr, 32'h20);
    chk("lk_aok0", a_aok, 2'b00);
    step();
    a_req = 2'b11; #1;
    chk("lk_saddr1", a_saddr, 32'h20);
    chk("lk_swdata", a_swdata, 32'hD1);
    step(); #1;
    chk("lk_saddr2", a_saddr, 32'h20);
    chk("lk_ssize", a_ssize, 2);
    step();
    a_saok = 1'b1; #1;
    chk("lk_aok", a_aok, 2'b10);
    chk("lk_swr", a_swr, 1);
    chk("lk_swstrb", a_swstrb, 4'hF);
    step();
    a_req = 2'b01; #1;
    chk("lk_next_saddr", a_saddr, 32'h10);
    chk("lk_next_aok", a_aok, 2'b01);
    step();
    a_req = 2'b00; a_sdok = 1'b1; #1;
    chk("lk_dok_ch1", a_dok, 2'b10);
    step(); #1;
    chk("lk_dok_ch0", a_dok, 2'b01);
    step();
    a_sdok = 1'b0;

    // in-order routing with read data
    a_addr = {32'h200, 32'h100}; a_req = 2'b01; #1;
    chk("ord_saddr0", a_saddr, 32'h100);
    step();
    a_req = 2'b10; #1;
    chk("ord_saddr1", a_saddr, 32'h200);
    chk("ord_aok1", a_aok, 2'b10);
    step();
    a_req = 2'b00; a_sdok = 1'b1; a_srdata = 32'hAAAA; #1;
    chk("ord_dok0", a_dok, 2'b01);
    chk("ord_rdata0", a_rdata, 32'hAAAA);
    step();
    a_srdata = 32'hBBBB; #1;
    chk("ord_dok1", a_dok, 2'b10);
    chk("ord_rdata1", a_rdata, 32'hBBBB);
    step();
    a_sdok = 1'b0; a_addr = {32'h20, 32'h10};

    // full: four accepts with no response
    a_req = 2'b01;
    step(); step(); step(); step(); #1;
    chk("full_sreq", a_sreq, 0);
    chk("full_cnt", a_cnt, 4);
    chk("full_aok", a_aok, 2'b00);
    a_sdok = 1'b1; #1;
    chk("full_pop_sreq", a_sreq, 0);
    chk("full_pop_dok", a_dok, 2'b01);
    step();
    a_sdok = 1'b0; #1;
    chk("full_reopen_sreq", a_sreq, 1);
    chk("full_reopen_cnt", a_cnt, 3);
    step(); #1;
    chk("full_again_cnt", a_cnt, 4);
    a_sdok = 1'b1;
    step(); #1;
    chk("pp_aok", a_aok, 2'b01);
    chk("pp_cnt_before", a_cnt, 3);
    step(); #1;
    chk("pp_cnt_after", a_cnt, 3);
    a_req = 2'b00;
    step(); step(); step();
    a_sdok = 1'b0; #1;
    chk("full_drain", a_cnt, 0);

    // unexpected response, then reset with outstanding + locked request
    a_sdok = 1'b1; #1;
    chk("unexp_dok", a_dok, 2'b00);
    step();
    a_sdok = 1'b0; #1;
    chk("unexp_err", a_err, 1);
    chk("unexp_cnt", a_cnt, 0);
    a_req = 2'b01; a_saok = 1'b1;
    step(); step();
    a_req = 2'b10; a_saok = 1'b0;
    step(); #1;
    chk("pre_rst_cnt", a_cnt, 2);
    reset = 1'b1; #1;
    chk("mid_rst_sreq", a_sreq, 0);
    chk("mid_rst_aok", a_aok, 2'b00);
    step();
    reset = 1'b0; a_req = 2'b11; #1;
    chk("post_rst_cnt", a_cnt, 0);
    chk("post_rst_err", a_err, 0);
    chk("post_rst_idle", a_saddr, 32'h10);
    a_req = 2'b00; a_sdok = 1'b1; #1;
    chk("late_dok", a_dok, 2'b00);
    step();
    a_sdok = 1'b0; #1;
    chk("late_err", a_err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter that merges several sram-like masters onto one sram-like slave port.
- Masters are the CPU fetch and load/store ports, plus future channels such as a cache refill or debug port.
- Supports multiple outstanding requests, in-order response routing via an ID FIFO, and selectable fixed-priority or round-robin arbitration.
- Sits between the CPU's inst/data sram-like interfaces and the single memory-side bridge.

Parameters:
- NUM_CH, 2, number of master channels (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wstrb width is DATA_W/8.
- MAX_OUTST, 4, maximum accepted-but-unanswered transactions (power of two, 2..16).
- RR_MODE, 0, arbitration mode: 0 = fixed priority (lower index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_req  in  NUM_CH  per-channel request
- m_wr  in  NUM_CH  per-channel write flag
- m_size  in  2*NUM_CH  per-channel size (0 = byte, 1 = half, 2 = word)
- m_wstrb  in  NUM_CH*DATA_W/8  per-channel byte strobes
- m_addr  in  NUM_CH*ADDR_W  per-channel address
- m_wdata  in  NUM_CH*DATA_W  per-channel write data
- m_addr_ok  out  NUM_CH  per-channel request accepted (one-hot or zero)
- m_data_ok  out  NUM_CH  per-channel response valid (one-hot or zero)
- m_rdata  out  DATA_W  read data, broadcast to all channels; valid for the channel whose m_data_ok is high
- s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  slave request fields
- s_addr_ok  in  1  slave accepted request
- s_data_ok  in  1  slave response
- s_rdata  in  DATA_W  slave read data
- outst_cnt  out  $clog2(MAX_OUTST)+1  current outstanding count
- err_unexp  out  1  sticky: s_data_ok arrived with nothing outstanding

Behaviour:
- Handshake rules (sram-like):
  - A request transfers in the cycle where req & addr_ok are both high.
  - A master holds req and all fields stable until it sees addr_ok.
  - The slave returns data_ok no earlier than the cycle after addr_ok, strictly in acceptance order.
- Slave request path:
  - s_req = (any eligible m_req) & (outst_cnt < MAX_OUTST) & ~reset.
  - s_* fields are muxed from the granted channel.
  - m_addr_ok[g] = s_req & s_addr_ok & (g == granted); all other bits are 0.
- Grant state machine, states IDLE and LOCK:
  - IDLE: the grant is computed combinationally from m_req.
    - RR_MODE = 0: the lowest-index requester wins.
    - RR_MODE = 1: search starts at rr_ptr and wraps modulo NUM_CH.
  - IDLE, s_req high and s_addr_ok low: register lock_ch = granted and go to LOCK.
  - LOCK: the grant is forced to lock_ch regardless of other requests, so s_* stays stable.
  - LOCK, s_req & s_addr_ok: return to IDLE.
  - A same-cycle accept in IDLE never enters LOCK.
- rr_ptr:
  - Updates only on accept, to (granted+1) mod NUM_CH.
  - Unused in RR_MODE = 0.
- ID FIFO (depth MAX_OUTST, width $clog2(NUM_CH)):
  - Push the granted index on accept.
  - Pop on s_data_ok.
  - Head index h drives m_data_ok[h] = s_data_ok; m_rdata = s_rdata combinationally (0-cycle latency).
  - Push and pop in the same cycle: the count is unchanged and pointers wrap modulo MAX_OUTST.
  - Full (cnt = MAX_OUTST): s_req is held low, even if a pop occurs that cycle, and new grants are deferred.
  - A locked request stays in LOCK with s_req low until the count drops.
- Unexpected response:
  - s_data_ok with an empty FIFO produces no m_data_ok and no pop.
  - err_unexp is set and stays set until reset.
- Reset values:
  - Registered state: FIFO empty, outst_cnt = 0, rr_ptr = 0, state IDLE, lock_ch = 0, err_unexp = 0.
  - While reset is high: s_req = 0, m_addr_ok = 0, m_data_ok = 0.
- Reset mid-operation drops all outstanding tracking; late slave responses after reset set err_unexp.
- Writes also consume a FIFO entry and receive data_ok; m_rdata is don't-care for writes.

Test Plan:
1. Fixed priority, RR_MODE = 0, both channels request continuously, slave addr_ok = 1 and data_ok 2 cycles later -> ch0 granted every cycle, ch1 starved, m_data_ok[0] pulses, outst_cnt settles at 2.
2. RR_MODE = 1, NUM_CH = 3, all channels request, addr_ok = 1 -> grant order 0,1,2,0,1; each channel receives its own data_ok in the same order.
3. Lock: ch1 requests with s_addr_ok = 0 for 3 cycles, ch0 raises req in cycle 2 -> s_addr/s_* stay on ch1 until accept; then ch0 is granted.
4. Full: MAX_OUTST = 4, 4 accepts with no data_ok -> s_req low, outst_cnt = 4; one data_ok -> next cycle s_req high, count 4 again after accept; same-cycle push/pop keeps the count constant.
5. Ordering: ch0 read 0x100 and ch1 read 0x200 accepted back to back; slave returns 0xAAAA then 0xBBBB -> m_data_ok[0] with 0xAAAA, then m_data_ok[1] with 0xBBBB.
6. Error and reset: s_data_ok with outst_cnt = 0 -> no m_data_ok, err_unexp = 1; reset asserted with 2 outstanding -> next cycle outst_cnt = 0, err_unexp = 0, state IDLE.
